// File: rtl/i2c_score_receiver_pkg.sv
// Shared types and constants for the I2C score-link receiver.
package i2c_score_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_e;

  localparam logic [6:0] DEFAULT_ADDRESS = 7'h42;
  localparam int         DEFAULT_FILTER  = 3;
  localparam logic [2:0] LAST_BIT        = 3'd7;
  localparam logic [3:0] INDEX_MAX       = 4'd15;

  // Bus conditions: SDA edge while SCL is high.
  function automatic logic is_start(input logic scl_level, input logic sda_fall);
    return scl_level & sda_fall;
  endfunction

  function automatic logic is_stop(input logic scl_level, input logic sda_rise);
    return scl_level & sda_rise;
  endfunction

endpackage

// File: rtl/i2c_score_receiver_line_filter.sv
// Two-flop synchronizer plus N-sample stability filter for one I2C line.
// Edge strobes are asserted in the same cycle the filtered level changes.
module i2c_line_filter #(
  parameter int FILTER = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic       sync1_q, sync2_q;
  logic       level_q, rise_q, fall_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= 3'd0;
      end else if (cnt_q == 3'(FILTER - 1)) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= 3'd0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_score_receiver.sv
// Write-only I2C target presenting received score bytes on a strobe interface.
// state    | meaning
// IDLE     | bus free or not ours, wait for START
// ADDR     | shifting address + R/W
// ADDR_ACK | pulling SDA low for address ACK
// DATA     | shifting a data byte
// DATA_ACK | pulling SDA low for data ACK
// IGNORE   | transfer addressed elsewhere or a read, wait for START/STOP
module i2c_score_receiver
  import i2c_score_receiver_pkg::*;
#(
  parameter logic [6:0] ADDRESS = DEFAULT_ADDRESS,
  parameter int         FILTER  = DEFAULT_FILTER
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic [3:0] rx_index_o,
  output logic       busy_o,
  output logic       error_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER(FILTER)) u_scl_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER(FILTER)) u_sda_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (sda_io),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic [3:0] rx_index_q;
  logic       busy_q, error_q;
  logic       start_det, stop_det;

  assign shift_d   = {shift_q[6:0], sda_lvl};
  assign start_det = is_start(scl_lvl, sda_fall);
  assign stop_det  = is_stop(scl_lvl, sda_rise);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_index_q <= 4'd0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_det || stop_det) begin
        // A bus condition mid-byte discards the partial byte.
        if (state_q == ST_DATA && bit_cnt_q != 3'd0) error_q <= 1'b1;
        state_q   <= start_det ? ST_ADDR : ST_IDLE;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: if (scl_rise) begin
            shift_q <= shift_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= 3'd0;
              if (shift_d[7:1] == ADDRESS && !shift_d[0]) begin
                state_q    <= ST_ADDR_ACK;
                busy_q     <= 1'b1;
                rx_index_q <= 4'd0;
                error_q    <= 1'b0;
              end else begin
                state_q <= ST_IGNORE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          ST_DATA: if (scl_rise) begin
            shift_q <= shift_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q  <= 3'd0;
              rx_data_q  <= shift_d;
              rx_valid_q <= 1'b1;
              state_q    <= ST_DATA_ACK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          // First SCL fall ends bit 8 and starts the ACK drive; the next ends bit 9.
          ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_DATA;
              if (state_q == ST_DATA_ACK && rx_index_q != INDEX_MAX)
                rx_index_q <= rx_index_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_io     = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_index_o = rx_index_q;
  assign busy_o     = busy_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_i2c_score_receiver.sv
// Directed bench: bit-banged I2C master with a scoreboard of expected received bytes.
module tb_i2c_score_receiver;

  localparam int Q = 20;
  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m_low;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_index;
  logic       busy, error;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];
  logic        low_seen;

  assign sda = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_score_receiver dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl_m),
    .sda_io    (sda),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_index_o(rx_index),
    .busy_o    (busy),
    .error_o   (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RxValid pops one expected {index, data}.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rx_unexpected observed data=%0h expected no strobe", rx_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e[7:0]));
        check("rx_index", 32'(rx_index), 32'(e[11:8]));
      end
    end
    if (!sda_m_low && sda === 1'b0) low_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clk(Q); sda_m_low = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m_low = 1'b1;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m_low = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m_low = 1'b0;
    wait_clk(H);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    wait_clk(Q); sda_m_low = ~b;
    if (glitch) begin
      wait_clk(1); scl_m = 1'b1;
      wait_clk(1); scl_m = 1'b0;
    end
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(H); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch_bit == i);
    wait_clk(Q); sda_m_low = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); ack = (sda === 1'b0);
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic push(input logic [3:0] idx, input logic [7:0] d);
    exp_q.push_back({idx, d});
  endtask

  initial begin
    logic ack;
    rst = 1'b1; scl_m = 1'b1; sda_m_low = 1'b0; low_seen = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_index", 32'(rx_index), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_error", 32'(error), 32'h0);
    check("reset_sda", 32'(sda), 32'h1);

    // Two-byte write to our address.
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack); check("t1_addr_ack", 32'(ack), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    push(4'd0, 8'h05); send_byte(8'h05, -1, ack); check("t1_b0_ack", 32'(ack), 32'h1);
    push(4'd1, 8'hA3); send_byte(8'hA3, -1, ack); check("t1_b1_ack", 32'(ack), 32'h1);
    i2c_stop();
    check("t1_busy_after_stop", 32'(busy), 32'h0);
    check("t1_pending", 32'(exp_q.size()), 32'h0);

    // Foreign address.
    low_seen = 1'b0;
    i2c_start();
    send_byte({7'h43, 1'b0}, -1, ack); check("t2_addr_nack", 32'(ack), 32'h0);
    check("t2_busy", 32'(busy), 32'h0);
    send_byte(8'hFF, -1, ack); check("t2_data_nack", 32'(ack), 32'h0);
    i2c_stop();
    check("t2_no_drive", 32'(low_seen), 32'h0);

    // Read request to our address.
    low_seen = 1'b0;
    i2c_start();
    send_byte({7'h42, 1'b1}, -1, ack); check("t3_read_nack", 32'(ack), 32'h0);
    send_byte(8'h00, -1, ack); check("t3_ignore_nack", 32'(ack), 32'h0);
    check("t3_busy", 32'(busy), 32'h0);
    i2c_stop();
    check("t3_no_drive", 32'(low_seen), 32'h0);

    // STOP mid-byte sets Error; next address match clears it.
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack);
    push(4'd0, 8'h11); send_byte(8'h11, -1, ack); check("t4_b0_ack", 32'(ack), 32'h1);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    i2c_stop();
    check("t4_error_set", 32'(error), 32'h1);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_pending", 32'(exp_q.size()), 32'h0);
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack); check("t4_readdr_ack", 32'(ack), 32'h1);
    check("t4_error_clear", 32'(error), 32'h0);
    push(4'd0, 8'h22); send_byte(8'h22, -1, ack);
    i2c_stop();

    // 20-byte write: index saturates at 15.
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'(i * 7 + 3);
      push((i > 15) ? 4'd15 : 4'(i), d);
      send_byte(d, -1, ack);
      check("t5_ack", 32'(ack), 32'h1);
    end
    i2c_stop();
    check("t5_pending", 32'(exp_q.size()), 32'h0);
    check("t5_index_hold", 32'(rx_index), 32'hF);

    // One-cycle SCL glitch during data low phase.
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack);
    push(4'd0, 8'h5A); send_byte(8'h5A, 2, ack); check("t6_glitch_ack", 32'(ack), 32'h1);
    push(4'd1, 8'h3C); send_byte(8'h3C, 5, ack);
    i2c_stop();
    check("t6_pending", 32'(exp_q.size()), 32'h0);

    // Reset while the ACK is being driven.
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack);
    push(4'd0, 8'h81);
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 0, 1'b0);
    wait_clk(Q); sda_m_low = 1'b0;
    wait_clk(2);
    check("t7_ack_driven", 32'(sda), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t7_sda_released", 32'(sda), 32'h1);
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_rx_data", 32'(rx_data), 32'h00);
    wait_clk(1); rst = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(H); scl_m = 1'b0;
    i2c_stop();
    i2c_start();
    send_byte({7'h42, 1'b0}, -1, ack); check("t7_recover_ack", 32'(ack), 32'h1);
    push(4'd0, 8'h7E); send_byte(8'h7E, -1, ack);
    i2c_stop();
    check("t7_pending", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_score_receiver.md
# i2c_score_receiver

I2C write-only target that receives the score bytes the game logic transmits on SDA/SCL and presents each received byte on a parallel strobe interface. It sits on the far end of the score link, in the display/score-board design fed by the Pong board. Runs off the 100 MHz system clock and oversamples SCL/SDA; no SCL stretching.

## Interface
- ADDRESS, 7'h42, 7-bit target address this block acknowledges
- FILTER, 3, number of consecutive identical samples required before a filtered SCL/SDA level changes (1-7)

- Clock  input  1  system clock, 100 MHz
- Reset  input  1  synchronous, active-high; all state and outputs to reset values on the next rising Clock edge
- SCL  input  1  I2C clock from master (external pull-up)
- SDA  inout  1  I2C data; block drives only 1'b0 or 1'bz (open drain)
- RxData  output  8  last received data byte, MSB first on the wire
- RxValid  output  1  one-cycle pulse; RxData valid in that cycle
- RxIndex  output  4  index of RxData within the current transfer, 0 = first byte after address, saturates at 15
- Busy  output  1  high from START with address match until STOP or repeated START
- Error  output  1  sticky; set on STOP/START mid-byte during an addressed transfer, cleared by Reset or next address match

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then a FILTER-sample stability filter; edges taken on filtered levels.
- START: filtered SDA falls while filtered SCL high. STOP: filtered SDA rises while filtered SCL high. Both recognized in any state, including mid-byte; repeated START restarts address phase.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START; bit counter cleared.
  - ADDR: shift SDA on each SCL rise, MSB first; after 8th rise, compare bits[7:1] with ADDRESS. Match and R/W=0 -> ADDR_ACK, Busy=1, RxIndex=0, Error=0. Mismatch or R/W=1 -> IGNORE (NACK: SDA released).
  - ADDR_ACK: drive SDA low from next SCL fall until following SCL fall, then DATA.
  - DATA: shift 8 bits; on 8th SCL rise load RxData, pulse RxValid, go DATA_ACK.
  - DATA_ACK: drive SDA low for the 9th clock exactly as ADDR_ACK; then DATA; RxIndex increments (saturating at 15) at the transition.
  - IGNORE: never drives SDA; leaves only on START (-> ADDR) or STOP (-> IDLE).
- STOP in any state -> IDLE, Busy=0, SDA released. START/STOP with bit counter 1-7 in DATA sets Error; partial byte discarded, no RxValid.
- Master NACK is not applicable (write-only); 9th-bit SDA level from master ignored.
- Reset mid-transfer: SDA released immediately after the reset edge; block returns to IDLE and ignores bus until next START.

## Timing
- Reset values: RxData=8'h00, RxValid=0, RxIndex=0, Busy=0, Error=0, SDA=z, state IDLE.
- Input latency: pin change to filtered edge = 2 sync + FILTER cycles (5 at default).
- RxValid asserts the cycle after the filtered 8th SCL rise of a data byte; width exactly 1 cycle.
- ACK drive begins 1 cycle after filtered SCL fall ending bit 8, released 1 cycle after filtered SCL fall ending bit 9.
- Minimum supported SCL high/low time: 4 x (FILTER + 3) clock cycles; 100 kHz and 400 kHz at 100 MHz well inside.
- Busy rises 1 cycle after the address-match decision; falls 1 cycle after STOP detected.

## Structure
- Shared package: state encoding, START/STOP detect constants, default ADDRESS.
- One natural sub-module: i2c_line_filter (sync + stability filter + rise/fall strobes), instantiated twice for SCL and SDA.

## Test plan
- Write to 7'h42 with bytes 8'h05, 8'hA3, STOP -> ACK on address and both bytes; RxValid pulses twice with RxData 05 (RxIndex 0) then A3 (RxIndex 1); Busy falls after STOP.
- Address 7'h43 with byte 8'hFF -> SDA never driven low, no RxValid, Busy stays 0.
- Read request 7'h42 + R/W=1 -> NACK, IGNORE until STOP, no SDA drive.
- STOP after 4 bits of second byte -> Error=1, one RxValid only, Busy=0; next valid address clears Error.
- 20-byte write -> 20 RxValid pulses, RxIndex reads 0..15 then holds 15.
- Single-cycle glitch on SCL during data at FILTER=3 -> no extra bit shifted; Reset asserted mid-ACK -> SDA z next cycle, IDLE.
